// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, synchronous imem request tracking, IF/ID register
// and a one-entry skid buffer that parks an in-flight instruction across a stall.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_inst,
  output logic        ifid_valid,
  output logic        misalign,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {StBoot, StRun, StHold, StRedir} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_inst_q, ifid_inst_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  // The skid entry is older than the data currently on imem_rdata, so it drains first.
  logic        sel_valid;
  logic [31:0] sel_pc;
  logic [31:0] sel_inst;

  assign sel_valid = skid_valid_q | req_valid_q;
  assign sel_pc    = skid_valid_q ? skid_pc_q : req_pc_q;
  assign sel_inst  = skid_valid_q ? skid_inst_q : imem_rdata;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_valid_d   = req_valid_q;
    req_pc_d      = req_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_pc_d     = skid_pc_q;
    skid_inst_d   = skid_inst_q;
    ifid_pc_d     = ifid_pc_q;
    ifid_inst_d   = ifid_inst_q;
    ifid_valid_d  = ifid_valid_q;
    fetch_count_d = fetch_count_q;
    misalign_d    = 1'b0;

    if (branch_taken) begin
      pc_d         = {branch_target[31:2], 2'b00};
      req_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      ifid_pc_d    = 32'h0;
      ifid_inst_d  = NOP_INST;
      ifid_valid_d = 1'b0;
      misalign_d   = |branch_target[1:0];
      state_d      = StRedir;
    end else begin
      unique case (state_q)
        StBoot: begin
          pc_d         = pc_q + 32'd4;
          req_valid_d  = 1'b1;
          req_pc_d     = pc_q;
          ifid_pc_d    = 32'h0;
          ifid_inst_d  = NOP_INST;
          ifid_valid_d = 1'b0;
          state_d      = StRun;
        end
        StRun, StHold, StRedir: begin
          if (stall) begin
            // In HOLD req_valid is already clear, so the skid is left untouched.
            if (req_valid_q) begin
              skid_valid_d = 1'b1;
              skid_pc_d    = req_pc_q;
              skid_inst_d  = imem_rdata;
            end
            req_valid_d = 1'b0;
            state_d     = StHold;
          end else begin
            ifid_valid_d = sel_valid;
            ifid_pc_d    = sel_valid ? sel_pc : 32'h0;
            ifid_inst_d  = sel_valid ? sel_inst : NOP_INST;
            if (sel_valid) begin
              fetch_count_d = fetch_count_q + 32'd1;
            end
            skid_valid_d = 1'b0;
            if (skid_valid_q) begin
              req_valid_d = 1'b0;
            end else begin
              pc_d        = pc_q + 32'd4;
              req_valid_d = 1'b1;
              req_pc_d    = pc_q;
            end
            state_d = StRun;
          end
        end
        default: state_d = StBoot;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      req_valid_q   <= 1'b0;
      req_pc_q      <= 32'h0;
      skid_valid_q  <= 1'b0;
      skid_pc_q     <= 32'h0;
      skid_inst_q   <= 32'h0;
      ifid_pc_q     <= 32'h0;
      ifid_inst_q   <= NOP_INST;
      ifid_valid_q  <= 1'b0;
      misalign_q    <= 1'b0;
      fetch_count_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_valid_q   <= req_valid_d;
      req_pc_q      <= req_pc_d;
      skid_valid_q  <= skid_valid_d;
      skid_pc_q     <= skid_pc_d;
      skid_inst_q   <= skid_inst_d;
      ifid_pc_q     <= ifid_pc_d;
      ifid_inst_q   <= ifid_inst_d;
      ifid_valid_q  <= ifid_valid_d;
      misalign_q    <= misalign_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_inst   = ifid_inst_q;
  assign ifid_valid  = ifid_valid_q;
  assign misalign    = misalign_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus random stall/branch/reset traffic,
// checked against an address-level model of the fetch stream.
module tb_if_fetch_stage;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, stall = 1'b0, branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] imem_addr, imem_rdata, pc, ifid_pc, ifid_inst, fetch_count;
  logic        ifid_valid, misalign;

  logic        rst2 = 1'b1;
  logic [31:0] imem_addr2, imem_rdata2, pc2, ifid_pc2, ifid_inst2, fetch_count2;
  logic        ifid_valid2, misalign2;

  int n_checks = 0;
  int n_errors = 0;

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc(pc), .ifid_pc(ifid_pc), .ifid_inst(ifid_inst), .ifid_valid(ifid_valid),
    .misalign(misalign), .fetch_count(fetch_count)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst2), .stall(1'b0), .branch_taken(1'b0),
    .branch_target(32'h0), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .pc(pc2), .ifid_pc(ifid_pc2), .ifid_inst(ifid_inst2), .ifid_valid(ifid_valid2),
    .misalign(misalign2), .fetch_count(fetch_count2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h0060_0113;
      32'h8:   return 32'h0020_81B3;
      default: return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endcase
  endfunction

  // Synchronous instruction memory with one-cycle read latency.
  always @(posedge clk) begin
    imem_rdata  <= mem_word(imem_addr);
    imem_rdata2 <= mem_word(imem_addr2);
  end

  // Reference model: a PC, one outstanding request and one parked entry, tracked by address.
  logic [31:0] m_pc, m_rq, m_sp, m_ifid_pc, m_ifid_inst, m_cnt;
  logic        m_rv, m_sv, m_boot, m_valid, m_mis;

  function automatic void m_load(input logic [31:0] a);
    m_valid = 1'b1; m_ifid_pc = a; m_ifid_inst = mem_word(a); m_cnt = m_cnt + 1;
  endfunction

  function automatic void m_bubble();
    m_valid = 1'b0; m_ifid_pc = 32'h0; m_ifid_inst = Nop;
  endfunction

  function automatic void m_issue();
    m_rq = m_pc; m_rv = 1'b1; m_pc = m_pc + 4;
  endfunction

  function automatic void model_edge(input logic r, s, b, input logic [31:0] t);
    if (r) begin
      m_pc = 32'h0; m_rv = 0; m_sv = 0; m_boot = 1; m_cnt = 0; m_mis = 0; m_bubble();
    end else begin
      m_mis = 1'b0;
      if (b) begin
        m_pc = {t[31:2], 2'b00}; m_rv = 0; m_sv = 0; m_boot = 0; m_mis = |t[1:0];
        m_bubble();
      end else if (m_boot) begin
        m_boot = 0; m_bubble(); m_issue();
      end else if (s) begin
        if (m_rv) begin m_sv = 1; m_sp = m_rq; end
        m_rv = 0;
      end else if (m_sv) begin
        m_load(m_sp); m_sv = 0; m_rv = 0;
      end else begin
        if (m_rv) m_load(m_rq);
        else m_bubble();
        m_issue();
      end
    end
  endfunction

  function automatic logic [193:0] obs_vec();
    return {pc, imem_addr, (ifid_valid ? ifid_pc : 32'h0), ifid_inst, ifid_valid, misalign,
            fetch_count};
  endfunction

  function automatic logic [193:0] exp_vec();
    return {m_pc, m_pc, (m_valid ? m_ifid_pc : 32'h0), m_ifid_inst, m_valid, m_mis, m_cnt};
  endfunction

  task automatic step(input logic r, s, b, input logic [31:0] t);
    rst = r; stall = s; branch_taken = b; branch_target = t;
    @(posedge clk);
    model_edge(r, s, b, t);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 0);
      n_checks++;
      if (pc !== 32'h0 || ifid_inst !== Nop || ifid_valid !== 1'b0 || ifid_pc !== 32'h0 ||
          misalign !== 1'b0 || fetch_count !== 32'h0) begin
        n_errors++;
        $display("FAIL reset: got pc=%h inst=%h v=%b ipc=%h mis=%b cnt=%0d want 0/%h/0/0/0/0",
                 pc, ifid_inst, ifid_valid, ifid_pc, misalign, fetch_count, Nop);
      end
    end
  endtask

  task automatic test_startup();
    for (int i = 1; i <= 4; i++) begin
      step(0, 0, 0, 0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++; $display("FAIL startup edge %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i == 2) begin
        n_checks++;
        if ({ifid_pc, ifid_inst, ifid_valid} !== {32'h0, 32'h0050_0093, 1'b1}) begin
          n_errors++;
          $display("FAIL first_inst: got %h/%h/%b want 0/00500093/1", ifid_pc, ifid_inst,
                   ifid_valid);
        end
      end
      if (i == 4) begin
        n_checks++;
        if ({ifid_pc, ifid_inst, fetch_count} !== {32'h8, 32'h0020_81B3, 32'd3}) begin
          n_errors++;
          $display("FAIL third_inst: got %h/%h/%0d want 8/002081b3/3", ifid_pc, ifid_inst,
                   fetch_count);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held_pc, held_cnt;
    held_pc = ifid_pc; held_cnt = fetch_count;
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, 0);
      n_checks++;
      if (obs_vec() !== exp_vec() || ifid_pc !== held_pc || fetch_count !== held_cnt) begin
        n_errors++; $display("FAIL stall_hold %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++; $display("FAIL stall_release %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i == 0) begin
        n_checks++;
        if (ifid_pc !== held_pc + 4 || ifid_valid !== 1'b1 || fetch_count !== held_cnt + 1) begin
          n_errors++;
          $display("FAIL skid_drain: got pc=%h v=%b cnt=%0d want %h/1/%0d", ifid_pc,
                   ifid_valid, fetch_count, held_pc + 4, held_cnt + 1);
        end
      end
    end
  endtask

  task automatic test_branch();
    step(0, 0, 1, 32'h40);
    n_checks++;
    if (pc !== 32'h40 || ifid_valid !== 1'b0 || ifid_inst !== Nop || obs_vec() !== exp_vec())
    begin
      n_errors++; $display("FAIL branch_edge: got %h want %h", obs_vec(), exp_vec());
    end
    step(0, 0, 0, 0);
    n_checks++;
    if (pc !== 32'h44 || ifid_valid !== 1'b0) begin
      n_errors++; $display("FAIL branch_issue: got pc=%h v=%b want 44/0", pc, ifid_valid);
    end
    step(0, 0, 0, 0);
    n_checks++;
    if ({ifid_pc, ifid_inst, ifid_valid} !== {32'h40, mem_word(32'h40), 1'b1} ||
        obs_vec() !== exp_vec()) begin
      n_errors++; $display("FAIL branch_target: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_branch_over_stall();
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 32'h80);
    n_checks++;
    if (pc !== 32'h80 || ifid_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_errors++; $display("FAIL branch_stall: got %h want %h", obs_vec(), exp_vec());
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    n_checks++;
    if ({ifid_pc, ifid_valid} !== {32'h80, 1'b1} || obs_vec() !== exp_vec()) begin
      n_errors++; $display("FAIL branch_stall_target: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_misalign();
    step(0, 0, 1, 32'h42);
    n_checks++;
    if (misalign !== 1'b1 || pc !== 32'h40) begin
      n_errors++; $display("FAIL misalign_pulse: got mis=%b pc=%h want 1/40", misalign, pc);
    end
    step(0, 0, 0, 0);
    n_checks++;
    if (misalign !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_errors++; $display("FAIL misalign_clear: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_mid_hold();
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    n_checks++;
    if (pc !== 32'h0 || ifid_valid !== 1'b0 || fetch_count !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_hold: got pc=%h v=%b cnt=%0d want 0/0/0", pc, ifid_valid, fetch_count);
    end
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    n_checks++;
    if ({ifid_pc, ifid_inst, ifid_valid, fetch_count} !== {32'h0, 32'h0050_0093, 1'b1, 32'd1})
    begin
      n_errors++; $display("FAIL reset_restart: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      logic r, s, b;
      r = ($urandom_range(0, 99) < 2);
      s = ($urandom_range(0, 99) < 30);
      b = ($urandom_range(0, 99) < 8);
      step(r, s, b, $urandom & 32'h0000_03FF);
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_errors++;
        if (bad < 10) $display("FAIL random %0d: got %h want %h", i, obs_vec(), exp_vec());
        bad++;
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] want [4];
    want[0] = 32'hFFFF_FFF8; want[1] = 32'hFFFF_FFFC; want[2] = 32'h0; want[3] = 32'h4;
    rst2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0);
      rst2 = 1'b0;
      n_checks++;
      if (pc2 !== want[i]) begin
        n_errors++; $display("FAIL pc_wrap %0d: got %h want %h", i, pc2, want[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_stall();
    test_branch();
    test_branch_over_stall();
    test_misalign();
    test_reset_mid_hold();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the 5-stage pipeline CPU. It owns the PC register and drives the synchronous instruction memory, which has a fixed 1-cycle read latency. It also owns the IF/ID pipeline register and applies stall and branch redirects from ID/EX. A one-entry skid buffer keeps an in-flight instruction when a stall arrives, so no instruction is lost or duplicated.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0) written into IF/ID on flush or empty cycles

Ports:
clk  in  1  system clock; all state changes on its rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hazard unit load-use stall; hold PC and IF/ID
branch_taken  in  1  redirect request from EX; takes priority over stall
branch_target  in  32  redirect PC; bits [1:0] ignored
imem_addr  out  32  instruction memory address; combinational copy of pc
imem_rdata  in  32  memory data for the address presented on the previous cycle
pc  out  32  current fetch PC
ifid_pc  out  32  PC of the instruction held in IF/ID
ifid_inst  out  32  instruction held in IF/ID
ifid_valid  out  1  IF/ID holds a real instruction, not a bubble
misalign  out  1  one-cycle pulse: branch_target[1:0] != 0 on an accepted redirect
fetch_count  out  32  number of valid instructions loaded into IF/ID

Behaviour:
- Reset (rst=1 at an edge):
  - pc=RESET_PC, ifid_inst=NOP_INST, ifid_pc=0, ifid_valid=0, misalign=0, fetch_count=0.
  - Internal: req_valid=0, skid_valid=0, state=BOOT.
- req_valid/req_pc track the request issued last cycle; its data is on imem_rdata this cycle.
- Source select for an IF/ID load, in priority order:
  - skid entry, if skid_valid;
  - else imem_rdata with ifid_pc=req_pc, if req_valid;
  - else bubble (NOP_INST, valid=0).
- States:
  - BOOT: first non-reset edge. pc<=pc+4, req_valid<=1, req_pc<=pc, IF/ID<=bubble. Next state RUN.
  - RUN, stall=0, branch_taken=0:
    - IF/ID<=selected source; skid_valid<=0.
    - If skid was used, no new request this edge: req_valid<=0, pc holds.
    - Otherwise pc<=pc+4, req_valid<=1, req_pc<=pc.
  - RUN, stall=1: pc and IF/ID hold. If req_valid, capture {req_pc, imem_rdata} into skid; req_valid<=0. Next state HOLD.
  - HOLD, stall=1: everything holds; skid unchanged.
  - HOLD, stall=0: behaves as RUN with stall=0, so the skid drains first. Next state RUN.
  - Any state, branch_taken=1 (overrides stall):
    - pc<={branch_target[31:2],2'b00}; IF/ID<=bubble; req_valid<=0; skid_valid<=0.
    - misalign<=|branch_target[1:0]. Next state REDIR.
  - REDIR: issues the target (pc<=pc+4, req_valid<=1). Honours stall and branch_taken exactly as RUN. Next state RUN.
- Latency:
  - First instruction (@RESET_PC) is in IF/ID after the 2nd edge following reset release.
  - Branch target instruction is in IF/ID 2 edges after the branch_taken edge (2-cycle penalty).
- fetch_count increments by 1 on every edge that loads IF/ID with valid=1. It wraps mod 2^32.
- PC arithmetic is mod 2^32: 32'hFFFF_FFFC+4 → 0, with no flag.
- A held IF/ID does not re-increment fetch_count.
- rst asserted mid-stall or mid-redirect restores all reset values on that edge. A pending skid entry is discarded.
- A stall with no outstanding request (req_valid=0) leaves the skid empty.

Test Plan:
- Reset release with imem = {A0:00500093, A4:00600113, A8:002081B3} and RESET_PC=0 → IF/ID after edge 2 = (0, 00500093, valid=1); after edge 4 = (8, 002081B3); fetch_count=3.
- Stall asserted 2 cycles while request for PC=4 is in flight → IF/ID holds PC=0 instruction; on release IF/ID=(4, 00600113) then (8, ...); no duplicate or skip; fetch_count increments once per instruction.
- branch_taken with branch_target=0x40 while fetching 0x8 → next IF/ID = NOP_INST/valid=0; 2 edges later IF/ID=(0x40, mem[0x40]); pc sequence 0x40, 0x44.
- branch_taken and stall both high in the same cycle, with a skid entry present → redirect wins, skid cleared, IF/ID bubble; target fetched as in the previous scenario.
- branch_target=0x42 → misalign pulses for 1 cycle; pc=0x40.
- RESET_PC=32'hFFFF_FFF8, free-running → pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst asserted during a HOLD with skid_valid=1 → next edge: pc=RESET_PC, ifid_valid=0, fetch_count=0; restart as in the first scenario.
